ts_capture_sched: RTL and testbench

- Captures the free-running 64-bit timestamp counter value on asynchronous-origin event pulses from N encoder channels, already synchronised upstream.
- Holds one pending timestamp per channel.
- Round-robin arbitration shares a single output stream between channels; the stream feeds the DMA/FIFO path to the PS.
- Sits between the timestamp counter block and the record FIFO.

---
 rtl/ts_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/ts_capture_sched.sv | 129 ++++++++++++
 tb/tb_ts_capture_sched.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ts_pkg.sv
// Shared types and helpers for the timestamp capture/scheduling blocks.
package ts_pkg;

  localparam int TS_WIDTH_DEF = 64;
  localparam int N_CH_DEF     = 4;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Channel-id width; never below 1 so a single channel still has a field.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request after last_i, wrapping modulo N.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  int   cand;
  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(last_i) + k) % N;
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        idx_o       = W'(cand);
        gnt_o[cand] = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/ts_capture_sched.sv
// Per-channel timestamp capture slots feeding one valid/ready record stream,
// shared between channels by round-robin grant.
module ts_capture_sched
  import ts_pkg::*;
#(
  parameter int N_CH     = N_CH_DEF,
  parameter int TS_WIDTH = TS_WIDTH_DEF,
  parameter int CH_W     = clog2(N_CH)
) (
  input  logic                s_axi_aclk,
  input  logic                s_axi_arestn,
  input  logic [TS_WIDTH-1:0] counter_in,
  input  logic                enable,
  input  logic [N_CH-1:0]     ev_in,
  input  logic                ovf_clear,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [TS_WIDTH-1:0] m_ts,
  output logic [CH_W-1:0]     m_ch,
  output logic                m_lost,
  output logic [N_CH-1:0]     ovf_flags,
  output logic                busy
);

  out_state_e          state_q;
  logic [N_CH-1:0]     pend_q, pend_d;
  logic [N_CH-1:0]     lost_q, lost_d;
  logic [N_CH-1:0]     ovf_q, ovf_d;
  logic [TS_WIDTH-1:0] ts_q [N_CH];
  logic [TS_WIDTH-1:0] ts_d [N_CH];
  logic [CH_W-1:0]     last_q;
  logic                m_valid_q, m_lost_q;
  logic [TS_WIDTH-1:0] m_ts_q;
  logic [CH_W-1:0]     m_ch_q;

  logic [N_CH-1:0]     gnt;
  logic [CH_W-1:0]     gnt_idx;
  logic                any_pend;
  logic                grant_fire;

  rr_arbiter #(.N(N_CH), .W(CH_W)) u_arb (
    .req_i  (pend_q),
    .last_i (last_q),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx),
    .any_o  (any_pend)
  );

  // A grant happens whenever the output register is empty or is being drained.
  assign grant_fire = any_pend & ((state_q == OUT_EMPTY) | m_ready);

  // A slot being granted on this edge counts as free, so its new event is kept.
  always_comb begin
    pend_d = pend_q;
    lost_d = lost_q;
    ovf_d  = ovf_clear ? '0 : ovf_q;
    for (int i = 0; i < N_CH; i++) begin
      ts_d[i] = ts_q[i];
      if (grant_fire && gnt[i]) begin
        pend_d[i] = 1'b0;
        lost_d[i] = 1'b0;
      end
      if (ev_in[i] && enable) begin
        if (!pend_q[i] || (grant_fire && gnt[i])) begin
          ts_d[i]   = counter_in;
          pend_d[i] = 1'b1;
        end else begin
          lost_d[i] = 1'b1;
          ovf_d[i]  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_arestn) begin
      state_q   <= OUT_EMPTY;
      pend_q    <= '0;
      lost_q    <= '0;
      ovf_q     <= '0;
      last_q    <= CH_W'(N_CH - 1);
      m_valid_q <= 1'b0;
      m_ts_q    <= '0;
      m_ch_q    <= '0;
      m_lost_q  <= 1'b0;
      for (int i = 0; i < N_CH; i++) ts_q[i] <= '0;
    end else begin
      pend_q <= pend_d;
      lost_q <= lost_d;
      ovf_q  <= ovf_d;
      for (int i = 0; i < N_CH; i++) ts_q[i] <= ts_d[i];
      case (state_q)
        OUT_EMPTY: begin
          if (grant_fire) begin
            state_q   <= OUT_FULL;
            m_valid_q <= 1'b1;
            m_ts_q    <= ts_q[gnt_idx];
            m_ch_q    <= gnt_idx;
            m_lost_q  <= lost_q[gnt_idx];
            last_q    <= gnt_idx;
          end
        end
        OUT_FULL: begin
          if (grant_fire) begin
            m_ts_q   <= ts_q[gnt_idx];
            m_ch_q   <= gnt_idx;
            m_lost_q <= lost_q[gnt_idx];
            last_q   <= gnt_idx;
          end else if (m_ready) begin
            state_q   <= OUT_EMPTY;
            m_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= OUT_EMPTY;
          m_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign m_valid   = m_valid_q;
  assign m_ts      = m_ts_q;
  assign m_ch      = m_ch_q;
  assign m_lost    = m_lost_q;
  assign ovf_flags = ovf_q;
  assign busy      = (|pend_q) | m_valid_q;

endmodule

// File: tb/tb_ts_capture_sched.sv
// Directed bench for ts_capture_sched: expected records are queued as events
// are driven and compared whenever a record is handed off downstream.
module tb_ts_capture_sched;

  localparam int N_CH     = 4;
  localparam int TS_WIDTH = 64;
  localparam int CH_W     = 2;

  logic                s_axi_aclk;
  logic                s_axi_arestn;
  logic [TS_WIDTH-1:0] counter_in;
  logic                enable;
  logic [N_CH-1:0]     ev_in;
  logic                ovf_clear;
  logic                m_valid;
  logic                m_ready;
  logic [TS_WIDTH-1:0] m_ts;
  logic [CH_W-1:0]     m_ch;
  logic                m_lost;
  logic [N_CH-1:0]     ovf_flags;
  logic                busy;

  typedef struct {
    logic [TS_WIDTH-1:0] ts;
    logic [CH_W-1:0]     ch;
    logic                lost;
  } rec_t;

  rec_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  ts_capture_sched #(.N_CH(N_CH), .TS_WIDTH(TS_WIDTH), .CH_W(CH_W)) dut (
    .s_axi_aclk   (s_axi_aclk),
    .s_axi_arestn (s_axi_arestn),
    .counter_in   (counter_in),
    .enable       (enable),
    .ev_in        (ev_in),
    .ovf_clear    (ovf_clear),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_ts         (m_ts),
    .m_ch         (m_ch),
    .m_lost       (m_lost),
    .ovf_flags    (ovf_flags),
    .busy         (busy)
  );

  initial s_axi_aclk = 1'b0;
  always #5 s_axi_aclk = ~s_axi_aclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void push_rec(input logic [TS_WIDTH-1:0] ts, input int ch, input logic lost);
    rec_t r;
    r.ts   = ts;
    r.ch   = CH_W'(ch);
    r.lost = lost;
    exp_q.push_back(r);
  endfunction

  // Free-running counter advances one step per clock, as the real counter does.
  task automatic tick();
    @(posedge s_axi_aclk);
    #1;
    counter_in = counter_in + 1;
  endtask

  task automatic do_reset();
    s_axi_arestn = 1'b0;
    tick();
    tick();
    s_axi_arestn = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (!busy && exp_q.size() == 0) break;
      tick();
    end
    check(tag, {63'b0, (busy | (exp_q.size() != 0))}, 64'd0);
  endtask

  // Scoreboard side: every handshake must match the oldest queued expectation.
  always @(negedge s_axi_aclk) begin
    if (s_axi_arestn && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("[TB] FAIL unexpected_record: observed ch=%0d ts=%h expected none", m_ch, m_ts);
      end else begin
        rec_t r;
        r = exp_q.pop_front();
        check("rec_ts", m_ts, r.ts);
        check("rec_ch", {62'b0, m_ch}, {62'b0, r.ch});
        check("rec_lost", {63'b0, m_lost}, {63'b0, r.lost});
      end
    end
  end

  initial begin
    s_axi_arestn = 1'b0;
    counter_in   = 64'h100;
    enable       = 1'b1;
    ev_in        = '0;
    ovf_clear    = 1'b0;
    m_ready      = 1'b1;
    tick(); tick(); tick();
    check("rst_valid", {63'b0, m_valid}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_ovf", {60'b0, ovf_flags}, 64'd0);
    check("rst_ts", m_ts, 64'd0);
    check("rst_ch", {62'b0, m_ch}, 64'd0);
    check("rst_lost", {63'b0, m_lost}, 64'd0);
    s_axi_arestn = 1'b1;
    tick();

    // Single event: two-cycle latency, one beat.
    counter_in = 64'h105;
    push_rec(64'h105, 0, 1'b0);
    ev_in = 4'b0001;
    tick();
    ev_in = '0;
    check("t1_lat_early", {63'b0, m_valid}, 64'd0);
    tick();
    check("t1_valid", {63'b0, m_valid}, 64'd1);
    check("t1_busy", {63'b0, busy}, 64'd1);
    tick();
    check("t1_single_beat", {63'b0, m_valid}, 64'd0);
    wait_idle("t1_drain");

    // All channels at once, fresh priority: 0,1,2,3 back to back.
    do_reset();
    counter_in = 64'h200;
    for (int c = 0; c < 4; c++) push_rec(64'h200, c, 1'b0);
    ev_in = 4'b1111;
    tick();
    ev_in = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t2_b2b_valid", {63'b0, m_valid}, 64'd1);
    end
    tick();
    check("t2_end_valid", {63'b0, m_valid}, 64'd0);
    check("t2_end_busy", {63'b0, busy}, 64'd0);

    // Stalled output: first event moves to the output register, second fills
    // the slot, third is dropped and marks the second record as lossy.
    m_ready = 1'b0;
    push_rec(64'h300, 2, 1'b0);
    push_rec(64'h310, 2, 1'b1);
    counter_in = 64'h300; ev_in = 4'b0100; tick();
    ev_in = '0; tick(); tick();
    counter_in = 64'h310; ev_in = 4'b0100; tick();
    counter_in = 64'h320; ev_in = 4'b0100; tick();
    ev_in = '0;
    check("t3_ovf", {60'b0, ovf_flags}, 64'h4);
    check("t3_hold_ts", m_ts, 64'h300);
    m_ready = 1'b1;
    wait_idle("t3_drain");
    push_rec(64'h330, 2, 1'b0);
    counter_in = 64'h330; ev_in = 4'b0100; tick();
    ev_in = '0;
    wait_idle("t3_after_drain");

    // Fairness: ch0/ch1 pulsed for 6 edges; grants alternate starting with ch0.
    counter_in = 64'h400;
    for (int j = 1; j <= 7; j++)
      push_rec(64'h400 + ((j < 2) ? 0 : j - 2), (j % 2 == 1) ? 0 : 1,
               (j == 1 || j == 7) ? 1'b0 : 1'b1);
    ev_in = 4'b0011;
    for (int k = 0; k < 6; k++) tick();
    ev_in = '0;
    wait_idle("t4_drain");

    ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
    check("t4_ovf_cleared", {60'b0, ovf_flags}, 64'd0);

    // Event on ch1 at the edge its slot is granted is kept, not lost.
    push_rec(64'h500, 1, 1'b0);
    push_rec(64'h501, 1, 1'b0);
    counter_in = 64'h500;
    ev_in = 4'b0010;
    tick(); tick();
    ev_in = '0;
    wait_idle("t5a_drain");
    check("t5a_no_ovf", {60'b0, ovf_flags}, 64'd0);

    // Drop on ch3 coincident with ovf_clear keeps that flag set.
    m_ready = 1'b0;
    push_rec(64'h700, 3, 1'b0);
    push_rec(64'h710, 3, 1'b1);
    counter_in = 64'h700; ev_in = 4'b1000; tick();
    ev_in = '0; tick();
    counter_in = 64'h710; ev_in = 4'b1000; tick();
    counter_in = 64'h720; ev_in = 4'b1000; tick();
    check("t5b_ovf_set", {60'b0, ovf_flags}, 64'h8);
    counter_in = 64'h730; ev_in = 4'b1000; ovf_clear = 1'b1; tick();
    ev_in = '0; ovf_clear = 1'b0;
    check("t5b_ovf_race", {60'b0, ovf_flags}, 64'h8);
    m_ready = 1'b1;
    wait_idle("t5b_drain");
    ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
    check("t5b_ovf_clear", {60'b0, ovf_flags}, 64'd0);

    // Disabled capture ignores events entirely.
    enable = 1'b0;
    ev_in = 4'b1111; tick(); tick();
    ev_in = '0; tick();
    check("t6_dis_valid", {63'b0, m_valid}, 64'd0);
    check("t6_dis_busy", {63'b0, busy}, 64'd0);
    check("t6_dis_ovf", {60'b0, ovf_flags}, 64'd0);
    enable = 1'b1;

    // Reset mid-transfer discards the in-flight record and three pending slots.
    m_ready = 1'b0;
    counter_in = 64'h800;
    ev_in = 4'b1111; tick();
    ev_in = '0; tick();
    check("t6_pre_valid", {63'b0, m_valid}, 64'd1);
    check("t6_pre_busy", {63'b0, busy}, 64'd1);
    s_axi_arestn = 1'b0;
    tick();
    check("t6_rst_valid", {63'b0, m_valid}, 64'd0);
    check("t6_rst_busy", {63'b0, busy}, 64'd0);
    s_axi_arestn = 1'b1;
    m_ready = 1'b1;
    repeat (5) tick();
    check("t6_no_stale", {63'b0, m_valid}, 64'd0);
    check("t6_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
